// File: rtl/fpga_clock_reset_seq.sv
// ---------------------------------------------------------------------------
// fpga_clock_reset_seq
//
// Multi-channel clock/reset sequencer. Each of N_CH gated clock domains gets
// a clock enable (for a downstream BUFGCE) and an active-high reset. Every
// change of a domain's reset is bracketed by a clock-stopped window:
// HOLD_MARGIN cycles with ce_out low before the reset edge, SETUP_MARGIN
// cycles with ce_out low after it. Once the clock is running again it stays
// running for at least CE_MARGIN cycles before a new sequence may begin.
//
// Optional ordered release (SEQ_RELEASE = 1): a channel may only start a
// deassertion once the previous channel is idle and out of reset.
//
// Ports
//   clk_in   in   1     free-running source clock
//   rst_in   in   1     block reset, asynchronous, active-high
//   rst_req  in   N_CH  per-channel requested reset level (1 = in reset)
//   ce_out   out  N_CH  per-channel clock enable for the gated clock
//   rst_out  out  N_CH  per-channel reset, changes only while ce_out is low
//   busy     out  N_CH  high while the channel is sequencing (not in RUN)
// ---------------------------------------------------------------------------
module fpga_clock_reset_seq #(
  parameter int N_CH         = 4,
  parameter int HOLD_MARGIN  = 4,
  parameter int SETUP_MARGIN = 4,
  parameter int CE_MARGIN    = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int SEQ_RELEASE  = 0
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [N_CH-1:0] rst_req,
  output logic [N_CH-1:0] ce_out,
  output logic [N_CH-1:0] rst_out,
  output logic [N_CH-1:0] busy
);

  localparam int MAX_HS = (HOLD_MARGIN > SETUP_MARGIN) ? HOLD_MARGIN : SETUP_MARGIN;
  localparam int MAX_M  = (MAX_HS > CE_MARGIN) ? MAX_HS : CE_MARGIN;
  localparam int CW     = $clog2(MAX_M + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_MARGIN - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_MARGIN - 1);
  localparam logic [CW-1:0] CE_SAT     = CW'(CE_MARGIN);

  // Parameter sanity checks at elaboration.
  if (N_CH < 1) begin : g_err_nch
    $error("fpga_clock_reset_seq: N_CH must be at least 1");
  end
  if (HOLD_MARGIN < 1) begin : g_err_hold
    $error("fpga_clock_reset_seq: HOLD_MARGIN must be at least 1");
  end
  if (SETUP_MARGIN < 1) begin : g_err_setup
    $error("fpga_clock_reset_seq: SETUP_MARGIN must be at least 1");
  end
  if (CE_MARGIN < 1) begin : g_err_ce
    $error("fpga_clock_reset_seq: CE_MARGIN must be at least 1");
  end
  if (SYNC_STAGES < 0) begin : g_err_sync
    $error("fpga_clock_reset_seq: SYNC_STAGES must not be negative");
  end

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    SETUP = 2'd2
  } state_t;

  state_t          state   [N_CH];
  logic [CW-1:0]   cnt     [N_CH];
  logic [CW-1:0]   run_cnt [N_CH];
  logic [N_CH-1:0] target;
  logic [N_CH-1:0] req_s;
  logic [N_CH-1:0] blocked;

  // -------------------------------------------------------------------------
  // Input synchroniser. Flops reset to 1 so that a block reset never looks
  // like a release request.
  // -------------------------------------------------------------------------
  if (SYNC_STAGES == 0) begin : g_nosync
    assign req_s = rst_req;
  end else begin : g_sync
    logic [N_CH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
          sync_q[k] <= '1;
        end
      end else begin
        sync_q[0] <= rst_req;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    assign req_s = sync_q[SYNC_STAGES-1];
  end

  // -------------------------------------------------------------------------
  // Ordered release: a deassertion on channel i waits while channel i-1 is
  // still in reset or still sequencing. Assertions and channel 0 never wait.
  // -------------------------------------------------------------------------
  always_comb begin
    blocked = '0;
    if (SEQ_RELEASE != 0) begin
      for (int unsigned i = 1; i < N_CH; i++) begin
        blocked[i] = ~req_s[i] & rst_out[i] & (rst_out[i-1] | busy[i-1]);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel sequencer. The target level is latched when a sequence
  // starts; request changes while busy are ignored until back in RUN.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state[i]   <= SETUP;
        cnt[i]     <= '0;
        run_cnt[i] <= '0;
      end
      target  <= '1;
      ce_out  <= '0;
      rst_out <= '1;
      busy    <= '1;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        case (state[i])
          RUN: begin
            if (run_cnt[i] != CE_SAT) begin
              run_cnt[i] <= run_cnt[i] + 1'b1;
            end
            if ((req_s[i] != rst_out[i]) && (run_cnt[i] == CE_SAT) && !blocked[i]) begin
              state[i]  <= HOLD;
              target[i] <= req_s[i];
              ce_out[i] <= 1'b0;
              busy[i]   <= 1'b1;
              cnt[i]    <= '0;
            end
          end
          HOLD: begin
            if (cnt[i] == HOLD_LAST) begin
              rst_out[i] <= target[i];
              state[i]   <= SETUP;
              cnt[i]     <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          SETUP: begin
            if (cnt[i] == SETUP_LAST) begin
              ce_out[i]  <= 1'b1;
              busy[i]    <= 1'b0;
              state[i]   <= RUN;
              run_cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + 1'b1;
            end
          end
          default: begin
            state[i] <= SETUP;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpga_clock_reset_seq.sv
// ---------------------------------------------------------------------------
// Bench for fpga_clock_reset_seq. Two instances share clock and block reset:
//   A: SYNC_STAGES = 0, SEQ_RELEASE = 0 (independent channels, no sync)
//   B: SYNC_STAGES = 2, SEQ_RELEASE = 1 (ordered release, 2-flop sync)
// A timestamp-based model predicts every output each cycle; directed checks
// pin the model to hand-computed latencies; a monitor checks the margins.
// ---------------------------------------------------------------------------
module tb_fpga_clock_reset_seq;

  localparam int NC      = 4;
  localparam int HOLD_M  = 4;
  localparam int SETUP_M = 4;
  localparam int CE_M    = 4;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [NC-1:0] rq_a   = '1;
  logic [NC-1:0] rq_b   = '1;
  logic [NC-1:0] ce_a, rst_a, busy_a;
  logic [NC-1:0] ce_b, rst_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  fpga_clock_reset_seq #(
    .N_CH(NC), .HOLD_MARGIN(HOLD_M), .SETUP_MARGIN(SETUP_M),
    .CE_MARGIN(CE_M), .SYNC_STAGES(0), .SEQ_RELEASE(0)
  ) u_dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .rst_req(rq_a),
    .ce_out(ce_a), .rst_out(rst_a), .busy(busy_a)
  );

  fpga_clock_reset_seq #(
    .N_CH(NC), .HOLD_MARGIN(HOLD_M), .SETUP_MARGIN(SETUP_M),
    .CE_MARGIN(CE_M), .SYNC_STAGES(2), .SEQ_RELEASE(1)
  ) u_dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .rst_req(rq_b),
    .ce_out(ce_b), .rst_out(rst_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_min(input string name, input int act, input int need);
    n_cmp++;
    if (act < need) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d cycles, need at least %0d", name, $time, act, need);
    end
  endtask

  // -------------------------------------------------------------------------
  // Model: each channel is either idle (clock running) or inside a sequence
  // described by absolute edge numbers for the reset change and clock restart.
  // -------------------------------------------------------------------------
  int            n_edge = 0;
  logic [NC-1:0] m_ce   [2];
  logic [NC-1:0] m_rst  [2];
  logic [NC-1:0] m_busy [2];
  logic [NC-1:0] m_tgt  [2];
  logic [NC-1:0] hist   [2][2];
  int            chg_at    [2][NC];
  int            rise_at   [2][NC];
  int            last_rise [2][NC];

  always @(posedge clk_in) begin : model
    logic [NC-1:0] rq, rs, prst, pbusy;
    logic          blk;
    n_edge++;
    for (int d = 0; d < 2; d++) begin
      rq = (d == 0) ? rq_a : rq_b;
      if (rst_in) begin
        m_ce[d]    = '0;
        m_rst[d]   = '1;
        m_busy[d]  = '1;
        m_tgt[d]   = '1;
        hist[d][0] = '1;
        hist[d][1] = '1;
        for (int c = 0; c < NC; c++) begin
          chg_at[d][c]    = -1;
          rise_at[d][c]   = n_edge + SETUP_M;
          last_rise[d][c] = 0;
        end
      end else begin
        rs    = (d == 0) ? rq : hist[d][1];
        prst  = m_rst[d];
        pbusy = m_busy[d];
        for (int c = 0; c < NC; c++) begin
          if (m_busy[d][c]) begin
            if (n_edge == chg_at[d][c]) m_rst[d][c] = m_tgt[d][c];
            if (n_edge == rise_at[d][c]) begin
              m_ce[d][c]      = 1'b1;
              m_busy[d][c]    = 1'b0;
              last_rise[d][c] = n_edge;
            end
          end else begin
            blk = 1'b0;
            if (d == 1 && c > 0) begin
              blk = !rs[c] && prst[c] && (prst[c-1] || pbusy[c-1]);
            end
            if (rs[c] != m_rst[d][c] && (n_edge - last_rise[d][c]) > CE_M && !blk) begin
              m_ce[d][c]    = 1'b0;
              m_busy[d][c]  = 1'b1;
              m_tgt[d][c]   = rs[c];
              chg_at[d][c]  = n_edge + HOLD_M;
              rise_at[d][c] = n_edge + HOLD_M + SETUP_M;
            end
          end
        end
        hist[d][1] = hist[d][0];
        hist[d][0] = rq;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-cycle compare against the model, plus margin monitor.
  // -------------------------------------------------------------------------
  logic [NC-1:0] p_ce  [2];
  logic [NC-1:0] p_rst [2];
  int            low_len   [2][NC];
  int            high_len  [2][NC];
  int            since_tog [2][NC];
  logic          tog_seen  [2][NC];

  always @(negedge clk_in) begin : compare
    logic [NC-1:0] ac [2];
    logic [NC-1:0] ar [2];
    logic [NC-1:0] ab [2];
    ac[0] = ce_a; ar[0] = rst_a; ab[0] = busy_a;
    ac[1] = ce_b; ar[1] = rst_b; ab[1] = busy_b;
    if (rst_in) begin
      chk("reset ce a",   ac[0], '0); chk("reset rst a",  ar[0], '1); chk("reset busy a", ab[0], '1);
      chk("reset ce b",   ac[1], '0); chk("reset rst b",  ar[1], '1); chk("reset busy b", ab[1], '1);
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NC; c++) begin
          low_len[d][c] = 0; high_len[d][c] = 0; since_tog[d][c] = 0; tog_seen[d][c] = 1'b0;
        end
      end
    end else begin
      chk("model ce a",   ac[0], m_ce[0]); chk("model rst a",  ar[0], m_rst[0]); chk("model busy a", ab[0], m_busy[0]);
      chk("model ce b",   ac[1], m_ce[1]); chk("model rst b",  ar[1], m_rst[1]); chk("model busy b", ab[1], m_busy[1]);
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < NC; c++) begin
          if (ar[d][c] != p_rst[d][c]) begin
            chk_min("hold margin", ac[d][c] ? 0 : low_len[d][c], HOLD_M);
            tog_seen[d][c]  = 1'b1;
            since_tog[d][c] = 0;
          end
          if (ac[d][c] && !p_ce[d][c]) begin
            if (tog_seen[d][c]) chk_min("setup margin", since_tog[d][c], SETUP_M);
            tog_seen[d][c] = 1'b0;
          end
          if (!ac[d][c] && p_ce[d][c]) chk_min("ce margin", high_len[d][c], CE_M);
          if (ac[d][c]) begin
            high_len[d][c]++; low_len[d][c] = 0;
          end else begin
            low_len[d][c]++; high_len[d][c] = 0;
          end
          since_tog[d][c]++;
        end
      end
    end
    p_ce[0] = ac[0]; p_rst[0] = ar[0];
    p_ce[1] = ac[1]; p_rst[1] = ar[1];
  end

  // -------------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations. tick() leaves us 1ns
  // after a rising edge; inputs are driven 1ns later still.
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // Power-up
    repeat (3) tick();
    chk("pwr rst a", rst_a, 4'b1111);
    chk("pwr ce a",  ce_a,  4'b0000);
    chk("pwr busy b", busy_b, 4'b1111);
    #1 rst_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) chk("pwr ce still low", ce_a, 4'b0000);
      if (k == 4) begin
        chk("pwr ce up a",   ce_a,   4'b1111);
        chk("pwr busy a",    busy_a, 4'b0000);
        chk("pwr rst kept",  rst_a,  4'b1111);
        chk("pwr ce up b",   ce_b,   4'b1111);
      end
    end
    repeat (8) tick();

    // Single release of channel 0 on A
    #1 rq_a[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin
        chk("rel ce0 fall",  ce_a,  4'b1110);
        chk("rel rst others", rst_a, 4'b1111);
      end
      if (k == 4) chk("rel rst0 held", rst_a, 4'b1111);
      if (k == 5) chk("rel rst0 low",  rst_a, 4'b1110);
      if (k == 8) chk("rel ce0 low",   ce_a,  4'b1110);
      if (k == 9) begin
        chk("rel ce0 rise", ce_a,   4'b1111);
        chk("rel busy0",    busy_a, 4'b0000);
      end
    end

    // Glitch on channel 1 of A: first bring it out of reset
    #1 rq_a[1] = 1'b0;
    repeat (20) tick();
    chk("glitch pre rst", rst_a, 4'b1100);
    #1 rq_a[1] = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 2) #1 rq_a[1] = 1'b0;
      if (k == 1)  chk("glitch ce1 fall",  ce_a & 4'b0010, 4'b0000);
      if (k == 5)  chk("glitch rst1 up",   rst_a, 4'b1110);
      if (k == 9)  chk("glitch ce1 up",    ce_a,  4'b1111);
      if (k == 13) chk("glitch ce1 run",   ce_a,  4'b1111);
      if (k == 14) chk("glitch ce1 fall2", ce_a,  4'b1101);
      if (k == 17) chk("glitch rst1 held", rst_a, 4'b1110);
      if (k == 18) chk("glitch rst1 low",  rst_a, 4'b1100);
      if (k == 22) chk("glitch ce1 up2",   ce_a,  4'b1111);
    end

    // Ordered release on B
    #1 rq_b = 4'b0000;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 2)  chk("ord busy sync",   busy_b, 4'b0000);
      if (k == 3)  chk("ord busy ch0",    busy_b, 4'b0001);
      if (k == 7)  chk("ord rst ch0",     rst_b,  4'b1110);
      if (k == 11) chk("ord idle 0",      busy_b, 4'b0000);
      if (k == 12) chk("ord busy ch1",    busy_b, 4'b0010);
      if (k == 16) chk("ord rst ch1",     rst_b,  4'b1100);
      if (k == 21) chk("ord busy ch2",    busy_b, 4'b0100);
      if (k == 25) chk("ord rst ch2",     rst_b,  4'b1000);
      if (k == 30) chk("ord busy ch3",    busy_b, 4'b1000);
      if (k == 34) chk("ord rst ch3",     rst_b,  4'b0000);
      if (k == 38) chk("ord done ce",     ce_b,   4'b1111);
    end

    // Async reset while channel 2 of A is in HOLD
    #1 rq_a[2] = 1'b0;
    tick();
    chk("mid ce2 fall", ce_a, 4'b1011);
    tick();
    #1 rst_in = 1'b1;
    #1;
    chk("mid rst a",  rst_a,  4'b1111);
    chk("mid ce a",   ce_a,   4'b0000);
    chk("mid busy a", busy_a, 4'b1111);
    chk("mid rst b",  rst_b,  4'b1111);
    rq_a = 4'b1111;
    rq_b = 4'b1111;
    repeat (2) tick();
    #1 rst_in = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 3) chk("mid pwr ce low", ce_a, 4'b0000);
      if (k == 4) begin
        chk("mid pwr ce up",  ce_a,  4'b1111);
        chk("mid pwr rst",    rst_a, 4'b1111);
      end
    end

    // Random soak
    repeat (10) tick();
    for (int k = 0; k < 1000; k++) begin
      tick();
      #1;
      if ($urandom_range(0, 5) == 0) rq_a = 4'($urandom);
      if ($urandom_range(0, 5) == 0) rq_b = 4'($urandom);
    end
    rq_a = 4'b0000;
    rq_b = 4'b0000;
    repeat (80) tick();
    chk("soak end rst a", rst_a, 4'b0000);
    chk("soak end rst b", rst_b, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
